// File: rtl/fetch_sequencer_pkg.sv
// fetch_pkg: shared widths, opcode field position, HALT opcode and fetch state encoding
package fetch_pkg;
    localparam int PC_W = 8;
    localparam int INSTR_W = 16;
    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;
    localparam logic [OPC_MSB-OPC_LSB:0] HALT_OPCODE = 4'hF;
    typedef enum logic [1:0] {IDLE, REQ, HOLD, HALT} fetch_state_t;
endpackage

// File: rtl/fetch_sequencer_ir_buffer.sv
// fetch_ir_buffer: one-entry valid/ready register holding the fetched instruction and its pc
module fetch_ir_buffer
    import fetch_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               flush,
    input  logic               ready,
    input  logic [INSTR_W-1:0] load_instr,
    input  logic [PC_W-1:0]    load_pc,
    output logic               valid,
    output logic [INSTR_W-1:0] instr,
    output logic [PC_W-1:0]    pc
);
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            instr <= '0;
            pc    <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            instr <= load_instr;
            pc    <= load_pc;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end
endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: multi-cycle fetch controller owning the pc, with req/ack imem and valid/ready decode sides
// Optional HALT-opcode stop enabled by defining FETCH_HALT_EN.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = 8'h00
)(
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               stall,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               ir_valid,
    input  logic               ir_ready,
    output logic [INSTR_W-1:0] ir_instr,
    output logic [PC_W-1:0]    ir_pc,
    output logic               halted
);
    fetch_state_t state, state_nxt;
    logic [PC_W-1:0] pc, pc_nxt;
    logic capture, consume, halt_instr;

    assign imem_req  = state == REQ;
    assign imem_addr = pc;
    // a redirect in the same cycle as an ack discards the returned word
    assign capture   = imem_req && imem_ack && !redirect_valid;
    assign consume   = ir_valid && ir_ready;

`ifdef FETCH_HALT_EN
    assign halt_instr = ir_instr[OPC_MSB:OPC_LSB] == HALT_OPCODE;
    assign halted     = state == HALT;
`else
    assign halt_instr = 1'b0;
    assign halted     = 1'b0;
`endif

    fetch_ir_buffer u_buf (
        .clk       (clk),
        .rst       (rst),
        .load      (capture),
        .flush     (redirect_valid),
        .ready     (ir_ready),
        .load_instr(imem_rdata),
        .load_pc   (pc),
        .valid     (ir_valid),
        .instr     (ir_instr),
        .pc        (ir_pc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            pc    <= RESET_PC;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = capture ? pc + 1'b1 : pc;
        if (redirect_valid) begin
            state_nxt = IDLE;
            pc_nxt    = redirect_pc;
        end else begin
            case (state)
                IDLE:    state_nxt = stall ? IDLE : REQ;
                REQ:     state_nxt = imem_ack ? HOLD : REQ;
                HOLD:    state_nxt = !consume ? HOLD : halt_instr ? HALT : stall ? IDLE : REQ;
                HALT:    state_nxt = HALT;
                default: state_nxt = IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed scenarios plus randomized traffic checked against a
// transaction-level model (next fetch address + queue of fetched-but-undelivered pcs).
module tb_fetch_sequencer;
    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack = 1'b0;
    logic [15:0] imem_rdata = 16'h0;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [7:0]  redirect_pc = 8'h00;
    logic        ir_valid;
    logic        ir_ready = 1'b0;
    logic [15:0] ir_instr;
    logic [7:0]  ir_pc;
    logic        halted;

    int tests = 0;
    int fails = 0;
    int unsigned ack_rate = 0;
    bit halt_at3 = 1'b0;
    logic [7:0] exp_pc = 8'h00;
    logic [7:0] q[$];

    fetch_sequencer dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .ir_valid(ir_valid), .ir_ready(ir_ready), .ir_instr(ir_instr), .ir_pc(ir_pc),
        .halted(halted)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mem(input logic [7:0] a);
        mem = (halt_at3 && a == 8'h03) ? 16'hF000 : 16'h1000 + {8'h00, a};
    endfunction

    // update the model with this cycle's observed handshakes, then step one clock
    task automatic advance();
        if (rst) begin
            q.delete();
            exp_pc = 8'h00;
        end else begin
            if (ir_valid && ir_ready && q.size() > 0) void'(q.pop_front());
            if (redirect_valid) begin
                q.delete();
                exp_pc = redirect_pc;
            end else if (imem_req && imem_ack) begin
                q.push_back(exp_pc);
                exp_pc = exp_pc + 8'h01;
            end
        end
        @(posedge clk);
        #1;
        imem_ack   = imem_req && ($urandom_range(99) < ack_rate);
        imem_rdata = mem(imem_addr);
    endtask

    task automatic do_reset();
        rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0;
        advance();
        rst = 1'b0;
        advance();
    endtask

    task automatic test_reset();
        rst = 1'b1; ack_rate = 0;
        advance();
        advance();
        tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL reset_req got %b exp 0", imem_req); end
        tests++; if (ir_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b exp 0", ir_valid); end
        tests++; if (imem_addr !== 8'h00) begin fails++; $display("FAIL reset_pc got %h exp 00", imem_addr); end
        tests++; if (ir_instr !== 16'h0 || ir_pc !== 8'h00) begin fails++; $display("FAIL reset_ir got %h/%h exp 0000/00", ir_instr, ir_pc); end
        tests++; if (halted !== 1'b0) begin fails++; $display("FAIL reset_halted got %b exp 0", halted); end
        rst = 1'b0;
        advance();
        tests++; if (imem_req !== 1'b1 || imem_addr !== 8'h00) begin fails++; $display("FAIL first_req got %b/%h exp 1/00", imem_req, imem_addr); end
    endtask

    task automatic test_streaming();
        int k = 0;
        ack_rate = 100; ir_ready = 1'b1;
        imem_ack = imem_req; imem_rdata = mem(imem_addr);
        for (int i = 0; i < 6; i++) begin
            tests++; if (ir_valid !== 1'(i % 2)) begin fails++; $display("FAIL stream_valid cyc %0d got %b exp %0d", i, ir_valid, i % 2); end
            if (i % 2 == 1) begin
                tests++;
                if (ir_instr !== 16'h1000 + 16'(k) || ir_pc !== 8'(k)) begin
                    fails++; $display("FAIL stream_data got %h/%h exp %h/%h", ir_instr, ir_pc, 16'h1000 + 16'(k), 8'(k));
                end
                k++;
            end
            advance();
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] hi;
        logic [7:0] hp;
        int guard = 0;
        ir_ready = 1'b0;
        while (!ir_valid && guard < 8) begin advance(); guard++; end
        tests++; if (ir_valid !== 1'b1 || ir_pc !== 8'h03 || ir_instr !== 16'h1003) begin fails++; $display("FAIL bp_first got %b/%h/%h exp 1/03/1003", ir_valid, ir_pc, ir_instr); end
        hi = ir_instr; hp = ir_pc;
        repeat (5) begin
            advance();
            tests++; if (ir_valid !== 1'b1 || ir_instr !== hi || ir_pc !== hp || imem_req !== 1'b0) begin
                fails++; $display("FAIL bp_hold got v%b %h/%h req%b exp v1 %h/%h req0", ir_valid, ir_instr, ir_pc, imem_req, hi, hp);
            end
        end
        ir_ready = 1'b1;
        advance();
        tests++; if (ir_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 8'h04) begin fails++; $display("FAIL bp_release got v%b req%b %h exp v0 req1 04", ir_valid, imem_req, imem_addr); end
    endtask

    task automatic test_wrap();
        redirect_valid = 1'b1; redirect_pc = 8'hFF;
        advance();
        redirect_valid = 1'b0;
        tests++; if (imem_req !== 1'b0 || ir_valid !== 1'b0) begin fails++; $display("FAIL wrap_redir got req%b v%b exp 0 0", imem_req, ir_valid); end
        advance();
        tests++; if (imem_req !== 1'b1 || imem_addr !== 8'hFF) begin fails++; $display("FAIL wrap_req got %b/%h exp 1/ff", imem_req, imem_addr); end
        advance();
        tests++; if (ir_valid !== 1'b1 || ir_pc !== 8'hFF || ir_instr !== 16'h10FF) begin fails++; $display("FAIL wrap_data got %b/%h/%h exp 1/ff/10ff", ir_valid, ir_pc, ir_instr); end
        advance();
        tests++; if (imem_req !== 1'b1 || imem_addr !== 8'h00) begin fails++; $display("FAIL wrap_addr got %b/%h exp 1/00", imem_req, imem_addr); end
    endtask

    task automatic test_redirect();
        redirect_valid = 1'b1; redirect_pc = 8'h40;
        advance();
        redirect_valid = 1'b0;
        tests++; if (ir_valid !== 1'b0 || imem_req !== 1'b0) begin fails++; $display("FAIL redir_drop got v%b req%b exp 0 0", ir_valid, imem_req); end
        advance();
        tests++; if (imem_req !== 1'b1 || imem_addr !== 8'h40) begin fails++; $display("FAIL redir_req got %b/%h exp 1/40", imem_req, imem_addr); end
        advance();
        tests++; if (ir_valid !== 1'b1 || ir_pc !== 8'h40 || ir_instr !== 16'h1040) begin fails++; $display("FAIL redir_data got %b/%h/%h exp 1/40/1040", ir_valid, ir_pc, ir_instr); end
    endtask

    task automatic test_stall();
        stall = 1'b1;
        advance();
        tests++; if (imem_req !== 1'b0 || ir_valid !== 1'b0) begin fails++; $display("FAIL stall_idle got req%b v%b exp 0 0", imem_req, ir_valid); end
        repeat (3) begin
            advance();
            tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL stall_hold got req%b exp 0", imem_req); end
        end
        stall = 1'b0;
        advance();
        tests++; if (imem_req !== 1'b1 || imem_addr !== 8'h41) begin fails++; $display("FAIL stall_resume got %b/%h exp 1/41", imem_req, imem_addr); end
        advance();
        tests++; if (ir_valid !== 1'b1 || ir_pc !== 8'h41) begin fails++; $display("FAIL stall_data got %b/%h exp 1/41", ir_valid, ir_pc); end
        advance();
    endtask

    task automatic test_halt_opcode();
        int n = 0;
        int guard = 0;
        logic [15:0] li = 16'h0;
        logic [7:0] lp = 8'h00;
        halt_at3 = 1'b1; ack_rate = 100; ir_ready = 1'b1;
        do_reset();
        while (n < 4 && guard < 30) begin
            if (ir_valid) begin n++; li = ir_instr; lp = ir_pc; end
            advance();
            guard++;
        end
        tests++; if (n != 4) begin fails++; $display("FAIL halt_deliveries got %0d exp 4", n); end
        tests++; if (li !== 16'hF000 || lp !== 8'h03) begin fails++; $display("FAIL halt_word got %h/%h exp f000/03", li, lp); end
`ifdef FETCH_HALT_EN
        for (int i = 0; i < 8; i++) begin
            tests++; if (halted !== 1'b1 || imem_req !== 1'b0 || ir_valid !== 1'b0) begin
                fails++; $display("FAIL halt_stay cyc %0d got h%b req%b v%b exp 1 0 0", i, halted, imem_req, ir_valid);
            end
            advance();
        end
        redirect_valid = 1'b1; redirect_pc = 8'h10;
        advance();
        redirect_valid = 1'b0;
        tests++; if (halted !== 1'b0) begin fails++; $display("FAIL halt_clear got %b exp 0", halted); end
        advance();
        tests++; if (imem_req !== 1'b1 || imem_addr !== 8'h10) begin fails++; $display("FAIL halt_refetch got %b/%h exp 1/10", imem_req, imem_addr); end
        advance();
        tests++; if (ir_valid !== 1'b1 || ir_pc !== 8'h10 || ir_instr !== 16'h1010) begin fails++; $display("FAIL halt_data got %b/%h/%h exp 1/10/1010", ir_valid, ir_pc, ir_instr); end
`else
        tests++; if (halted !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 8'h04) begin
            fails++; $display("FAIL nohalt_continue got h%b req%b %h exp 0 1 04", halted, imem_req, imem_addr);
        end
`endif
        halt_at3 = 1'b0;
    endtask

    task automatic test_random();
        int deliveries = 0;
        logic prev_req;
        logic prev_stall;
        ack_rate = 50; ir_ready = 1'b0;
        do_reset();
        prev_req = 1'b0; prev_stall = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            tests++; if (ir_valid !== (q.size() != 0)) begin fails++; $display("FAIL rnd_valid cyc %0d got %b exp %0d", i, ir_valid, q.size()); end
            if (imem_req) begin
                tests++; if (imem_addr !== exp_pc) begin fails++; $display("FAIL rnd_addr cyc %0d got %h exp %h", i, imem_addr, exp_pc); end
            end
            if (ir_valid && q.size() > 0) begin
                tests++; if (ir_pc !== q[0] || ir_instr !== mem(q[0])) begin fails++; $display("FAIL rnd_data cyc %0d got %h/%h exp %h/%h", i, ir_pc, ir_instr, q[0], mem(q[0])); end
            end
            tests++; if (imem_req === 1'b1 && (ir_valid === 1'b1 || halted !== 1'b0)) begin fails++; $display("FAIL rnd_excl cyc %0d got req%b v%b h%b", i, imem_req, ir_valid, halted); end
            tests++; if (imem_req && !prev_req && prev_stall) begin fails++; $display("FAIL rnd_stall cyc %0d got req 1 exp 0", i); end
            stall          = $urandom_range(99) < 30;
            ir_ready       = $urandom_range(99) < 60;
            redirect_valid = $urandom_range(99) < 5;
            redirect_pc    = 8'($urandom);
            if (ir_valid && ir_ready) deliveries++;
            prev_req = imem_req; prev_stall = stall;
            advance();
        end
        tests++; if (deliveries < 100) begin fails++; $display("FAIL rnd_progress got %0d exp >=100", deliveries); end
        redirect_valid = 1'b0; stall = 1'b0;
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_wrap();
        test_redirect();
        test_stall();
        test_halt_opcode();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end
endmodule
